stack_vm: RTL
=============

STACK_VM -- requirements
Module: stack_vm

Interface
REQ-001 SHALL have parameter DATA_W, default 8: stack/result word width, 4..32.
REQ-002 SHALL have parameter STACK_DEPTH, default 8: stack entries, 2..64.
REQ-003 SHALL have parameter PROG_DEPTH, default 32: program bytes, 4..256.
REQ-004 SHALL have parameter MAX_STEPS, default 1024: instruction watchdog limit.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port prog_we  in  1  program-memory write strobe.
REQ-008 SHALL have port prog_addr  in  clog2(PROG_DEPTH)  program write address.
REQ-009 SHALL have port prog_wdata  in  8  program byte.
REQ-010 SHALL have port start  in  1  run request, sampled in IDLE only.
REQ-011 SHALL have port busy  out  1  high while state is RUN.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port result  out  DATA_W  top of stack at HALT; held until next done.
REQ-014 SHALL have port err  out  1  valid with done; 1 = run aborted.
REQ-015 SHALL have port err_code  out  3  abort cause; valid with done.

Function
REQ-016 SHALL implement states IDLE and RUN; IDLE+start -> RUN with pc=0, sp=0, step count=0, busy=1 from the next cycle.
REQ-017 SHALL execute exactly one instruction per clock in RUN; no pipelining.
REQ-018 SHALL decode opcodes: 0 PUSH imm (imm = next byte, zero-extended to DATA_W; pc+=2); 1 ADD; 3 SUB (second minus top); 4 DUP; 5 DROP; 6 JZ a (pop; pc=a if popped==0 else pc+=2); 7 JMP a; 2 HALT; each non-jump single-byte op pc+=1.
REQ-019 SHALL make ADD/SUB pop two and push one, modulo 2^DATA_W (no saturation, no carry flag).
REQ-020 On HALT SHALL register result=TOS, err=0, err_code=0, pulse done for one cycle, return to IDLE, busy=0 in the same cycle as done.
REQ-021 SHALL abort with err_code 1 on push when sp==STACK_DEPTH (PUSH, DUP).
REQ-022 SHALL abort with err_code 2 on stack underflow (ADD/SUB with sp<2; DUP/DROP/JZ/HALT with sp==0).
REQ-023 SHALL abort with err_code 3 on opcode >7, or pc (or pc+1 for two-byte ops, or a jump target) >= PROG_DEPTH.
REQ-024 SHALL abort with err_code 4 when step count reaches MAX_STEPS without HALT.
REQ-025 On abort SHALL pulse done with err=1, leave result unchanged, not modify the stack, return to IDLE.
REQ-026 SHALL accept prog_we writes only in IDLE; writes during RUN SHALL be ignored.
REQ-027 SHALL ignore start while busy; start in the cycle done is high SHALL be accepted (state is IDLE).
REQ-028 prog_we and start in the same IDLE cycle: write SHALL complete and be visible to the run started.
REQ-029 Error check priority when several apply: 3, then 2, then 1, then 4.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, busy=0, done=0, err=0, err_code=0, result=0, pc=0, sp=0, including mid-run.
REQ-031 Program memory SHALL NOT be cleared by reset; contents after power-up are undefined.
REQ-032 After rst_n deasserts, first start SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-033 Load {0,1,0,2,0,3,0,4,1,1,1,2}, start -> done 8 cycles after start edge, result=10, err=0.
REQ-034 DATA_W=8, {0,200,0,100,1,2} -> result=44; {0,3,0,5,3,2} -> result=254.
REQ-035 STACK_DEPTH=4, five consecutive PUSH -> done with err=1, err_code=1 on 5th PUSH; result unchanged.
REQ-036 {1,2} -> err_code 2; {9} -> err_code 3; {7,0} with MAX_STEPS=16 -> err_code 4 after 16 steps.
REQ-037 Countdown {0,3,4,6,12,0,1,3,7,2,...} style loop using JZ/JMP -> terminates at HALT with expected TOS and step count.
REQ-038 rst_n pulsed low mid-run -> busy/done/err=0 same cycle; rerun with unchanged program yields identical result.

Source files
------------

// File: rtl/stack_vm.sv
// Purpose : byte-coded stack machine; runs a program from local memory and reports TOS or a fault code.
// Latency : one instruction per clk in RUN; done pulses the cycle after the HALT/faulting instruction.
// Backpress: none; start is only sampled in IDLE, program writes are only accepted in IDLE.
//
// Ports:
//   clk, rst_n              - single clock, asynchronous active-low reset
//   prog_we/addr/wdata      - program byte write port (IDLE only)
//   start                   - run request (IDLE only)
//   busy                    - high while executing
//   done, err, err_code     - completion pulse with status (err_code 1 ovf, 2 unf, 3 prog, 4 watchdog)
//   result                  - TOS captured at HALT, held until the next successful HALT
module stack_vm #(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 8,
    parameter int PROG_DEPTH  = 32,
    parameter int MAX_STEPS   = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [7:0]                    prog_wdata,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             result,
    output logic                          err,
    output logic [2:0]                    err_code
);

    localparam int AW   = $clog2(PROG_DEPTH);
    // 9 bits holds any byte-sized jump target plus pc+2 past the last address.
    localparam int PC_W = 9;
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int SI_W = $clog2(STACK_DEPTH);
    localparam int SC_W = $clog2(MAX_STEPS + 1);

    localparam logic [PC_W-1:0] PC_LIM    = PC_W'(PROG_DEPTH);
    localparam logic [SP_W-1:0] SP_FULL   = SP_W'(STACK_DEPTH);
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(MAX_STEPS - 1);

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_ADD  = 3'd1,
        OP_HALT = 3'd2,
        OP_SUB  = 3'd3,
        OP_DUP  = 3'd4,
        OP_DROP = 3'd5,
        OP_JZ   = 3'd6,
        OP_JMP  = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_OVF  = 3'd1,
        ERR_UNF  = 3'd2,
        ERR_PROG = 3'd3,
        ERR_WDOG = 3'd4
    } err_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Storage: neither memory is reset; sp alone defines which stack entries are live.
    logic [7:0]        prog_mem  [PROG_DEPTH];
    logic [DATA_W-1:0] stack_mem [STACK_DEPTH];

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [SC_W-1:0]   step_q, step_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [2:0]        code_q, code_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              stk_we;
    logic [SI_W-1:0]   stk_waddr;
    logic [DATA_W-1:0] stk_wdata;

    // Fetch: opcode byte and the operand byte that follows it.
    logic [PC_W-1:0]   pc_nxt1, pc_nxt2, target;
    logic              pc_ok, arg_ok;
    logic [7:0]        op_byte, arg_byte;
    opcode_t           op;
    logic              op_bad;

    assign pc_nxt1  = pc_q + PC_W'(1);
    assign pc_nxt2  = pc_q + PC_W'(2);
    assign pc_ok    = pc_q < PC_LIM;
    assign arg_ok   = pc_nxt1 < PC_LIM;
    assign op_byte  = pc_ok  ? prog_mem[pc_q[AW-1:0]]    : 8'h00;
    assign arg_byte = arg_ok ? prog_mem[pc_nxt1[AW-1:0]] : 8'h00;
    assign op       = opcode_t'(op_byte[2:0]);
    assign op_bad   = |op_byte[7:3];
    assign target   = {1'b0, arg_byte};

    // Stack operands: tos = stack[sp-1], nos = stack[sp-2]; only consumed when sp is deep enough.
    logic [SI_W-1:0]   tos_idx, nos_idx, push_idx;
    logic [DATA_W-1:0] tos, nos;

    assign tos_idx  = SI_W'(sp_q - SP_W'(1));
    assign nos_idx  = SI_W'(sp_q - SP_W'(2));
    assign push_idx = SI_W'(sp_q);
    assign tos      = stack_mem[tos_idx];
    assign nos      = stack_mem[nos_idx];

    logic is_two_byte, is_jump, sp_lt2, sp_zero;

    assign is_two_byte = (op == OP_PUSH) || (op == OP_JZ) || (op == OP_JMP);
    assign is_jump     = (op == OP_JZ) || (op == OP_JMP);
    assign sp_lt2      = sp_q < SP_W'(2);
    assign sp_zero     = sp_q == '0;

    // Fault detection in priority order. A JZ target is range-checked even when
    // the branch would fall through: the operand itself is malformed.
    err_t fault;

    always_comb begin
        fault = ERR_NONE;
        if (!pc_ok || op_bad || (is_two_byte && !arg_ok) || (is_jump && target >= PC_LIM)) begin
            fault = ERR_PROG;
        end else if ((((op == OP_ADD) || (op == OP_SUB)) && sp_lt2) ||
                     (((op == OP_HALT) || (op == OP_DUP) || (op == OP_DROP) || (op == OP_JZ)) && sp_zero)) begin
            fault = ERR_UNF;
        end else if (((op == OP_PUSH) || (op == OP_DUP)) && (sp_q == SP_FULL)) begin
            fault = ERR_OVF;
        end else if ((op != OP_HALT) && (step_q == STEP_LAST)) begin
            // This instruction would be the MAX_STEPS-th without reaching HALT.
            fault = ERR_WDOG;
        end
    end

    // Next-state / execute.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        step_d    = step_q;
        done_d    = 1'b0;
        err_d     = err_q;
        code_d    = code_q;
        result_d  = result_q;
        stk_we    = 1'b0;
        stk_waddr = '0;
        stk_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    sp_d    = '0;
                    step_d  = '0;
                end
            end

            S_RUN: begin
                step_d = step_q + SC_W'(1);
                if (fault != ERR_NONE) begin
                    // Abort leaves the stack and result untouched.
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    code_d  = fault;
                end else begin
                    case (op)
                        OP_PUSH: begin
                            stk_we    = 1'b1;
                            stk_waddr = push_idx;
                            stk_wdata = DATA_W'(arg_byte);
                            sp_d      = sp_q + SP_W'(1);
                            pc_d      = pc_nxt2;
                        end
                        OP_ADD: begin
                            stk_we    = 1'b1;
                            stk_waddr = nos_idx;
                            stk_wdata = nos + tos;
                            sp_d      = sp_q - SP_W'(1);
                            pc_d      = pc_nxt1;
                        end
                        OP_SUB: begin
                            stk_we    = 1'b1;
                            stk_waddr = nos_idx;
                            stk_wdata = nos - tos;
                            sp_d      = sp_q - SP_W'(1);
                            pc_d      = pc_nxt1;
                        end
                        OP_DUP: begin
                            stk_we    = 1'b1;
                            stk_waddr = push_idx;
                            stk_wdata = tos;
                            sp_d      = sp_q + SP_W'(1);
                            pc_d      = pc_nxt1;
                        end
                        OP_DROP: begin
                            sp_d = sp_q - SP_W'(1);
                            pc_d = pc_nxt1;
                        end
                        OP_JZ: begin
                            sp_d = sp_q - SP_W'(1);
                            pc_d = (tos == '0) ? target : pc_nxt2;
                        end
                        OP_JMP: begin
                            pc_d = target;
                        end
                        OP_HALT: begin
                            state_d  = S_IDLE;
                            done_d   = 1'b1;
                            err_d    = 1'b0;
                            code_d   = ERR_NONE;
                            result_d = tos;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            sp_q     <= '0;
            step_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            step_q   <= step_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            result_q <= result_d;
        end
    end

    // Program writes land on the same edge that samples start, so a write issued
    // together with start is already visible to the first fetch.
    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && prog_we && (PC_W'(prog_addr) < PC_LIM)) begin
            prog_mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (stk_we) begin
            stack_mem[stk_waddr] <= stk_wdata;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign result   = result_q;

endmodule
